gnrl_pipe_dff: RTL and testbench
================================

// Module: gnrl_pipe_dff
// PURPOSE
//  Handshaked pipeline register stage built as a two-entry skid buffer.
//  Successor to the plain enable-DFF: adds valid/ready flow control, flush,
//  occupancy reporting, and a registered in_ready so that no combinational
//  ready path crosses the stage.
//  Placed between core pipeline stages (IF/ID, ID/EX, ...) so that one stage
//  can stall without losing throughput.
// PARAMETERS
//  DW  32  payload width in bits
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous, active-low reset
//  data_ini    in   DW   value loaded into both data registers during reset
//  flush       in   1    discard all held entries (synchronous)
//  in_valid    in   1    upstream presents in_data
//  in_ready    out  1    stage can accept; registered, equals !skid_valid
//  in_data     in   DW   upstream payload
//  out_valid   out  1    out_data is valid; equals main_valid
//  out_ready   in   1    downstream accepts
//  out_data    out  DW   downstream payload; equals main_data
//  level       out  2    held entries: 0, 1 or 2
// BEHAVIOUR
//  - Reset (rst_n low, async):
//    - main_valid=0, skid_valid=0.
//    - main_data=skid_data=data_ini.
//    - Outputs: in_ready=1, out_valid=0, out_data=data_ini, level=0.
//    - No transfer is recorded while rst_n is low.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - States are encoded by {skid_valid, main_valid}:
//    - EMPTY = 00, BUSY = 01, FULL = 11. Code 10 is illegal and unreachable.
//  - EMPTY:
//    - in_fire -> BUSY, main_data<=in_data.
//  - BUSY:
//    - in_fire & out_fire -> BUSY, main_data<=in_data.
//    - in_fire & !out_fire -> FULL, skid_data<=in_data.
//    - !in_fire & out_fire -> EMPTY.
//    - Otherwise hold.
//  - FULL (in_ready=0):
//    - out_fire -> BUSY, main_data<=skid_data.
//    - Otherwise hold.
//  - Latency and throughput:
//    - in_fire at edge N makes the data visible on out_data after edge N (1 cycle).
//    - Sustains 1 transfer per cycle with out_ready held high.
//  - Ordering: strict FIFO, no duplication, no loss (except on flush).
//  - flush has priority over all other events:
//    - Next state is EMPTY.
//    - An in_fire in the same cycle is dropped.
//    - An out_fire in the same cycle still counts as consumed downstream.
//    - Data registers are not modified by flush.
//    - in_ready is 1 in the following cycle.
//  - Data registers load only on the events listed above; otherwise they hold.
//    - out_data is never X after reset, even when out_valid=0.
//  - level = main_valid + skid_valid.
//  - Reset asserted mid-transfer: immediate return to reset values; held data is lost.
//  - out_data is a stable register output; no combinational in->out path exists.
// TESTING
//  1. Reset with data_ini=32'hDEAD_BEEF -> out_valid=0, in_ready=1, level=0,
//     out_data=32'hDEAD_BEEF.
//  2. Stream 1,2,3,4 with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles,
//     each 1 cycle after in_fire; level stays 1.
//  3. Push 5,6 with out_ready=0 -> level=2, in_ready=0, 7 held off.
//     Then raise out_ready -> outputs 5,6,7 in order, no loss.
//  4. FULL (5,6) plus flush with in_valid=1 (data 9) -> next cycle level=0,
//     out_valid=0, in_ready=1; 9 never appears.
//  5. Random valid/ready for 10k cycles against a reference queue -> exact order
//     match; no out_valid with empty model; level matches model.
//  6. Assert rst_n low while FULL -> out_valid and level become 0 immediately.
//     After release, in_ready=1 and out_data=data_ini.

Source files
------------

// File: rtl/gnrl_pipe_dff.sv
// gnrl_pipe_dff: handshaked pipeline register stage built as a two-entry skid buffer.
// The main register always feeds the output. The skid register catches the one
// extra beat that arrives while downstream stalls. This keeps in_ready a pure
// register output.
module gnrl_pipe_dff #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_ini,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    level
);

    // State bits are {skid_valid, main_valid}; code 2'b10 is never entered.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t        state;
    logic [DW-1:0] main_data;
    logic [DW-1:0] skid_data;
    logic          main_valid;
    logic          skid_valid;
    logic          in_fire;
    logic          out_fire;

    assign main_valid = state[0];
    assign skid_valid = state[1];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    // Occupancy is simply the count of valid registers.
    always_comb begin
        level = {1'b0, skid_valid} + {1'b0, main_valid};
    end

    // Occupancy state machine. A flush empties the stage and drops any
    // simultaneous input. An illegal code also recovers to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) state <= BUSY;
                end
                BUSY: begin
                    if (in_fire && !out_fire) state <= FULL;
                    else if (!in_fire && out_fire) state <= EMPTY;
                end
                FULL: begin
                    if (out_fire) state <= BUSY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Payload registers load only on accepted beats or skid promotion.
    // Flush leaves the data untouched, so out_data never goes unknown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= data_ini;
            skid_data <= data_ini;
        end else if (!flush) begin
            case (state)
                EMPTY: begin
                    if (in_fire) main_data <= in_data;
                end
                BUSY: begin
                    if (in_fire && out_fire) main_data <= in_data;
                    else if (in_fire) skid_data <= in_data;
                end
                FULL: begin
                    if (out_fire) main_data <= skid_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnrl_pipe_dff.sv
// tb_gnrl_pipe_dff: directed and randomized checks of the skid-buffer pipeline stage.
module tb_gnrl_pipe_dff;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_ini;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    level;

    int tests_run;
    int tests_failed;

    logic [DW-1:0] model_q[$];

    gnrl_pipe_dff #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_ini  (data_ini),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    // 10 ns free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    // Advance one edge and settle just past it
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        data_ini     = 32'hDEAD_BEEF;
        rst_n        = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // 1. reset values
        #12;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_level", {30'b0, level}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'hDEAD_BEEF);
        rst_n = 1'b1;
        stepCycle();

        // 2. stream 1..4 with out_ready high: one cycle latency, level stays 1
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, DW'(k), 1'b1, 1'b0);
            stepCycle();
            checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stream_data", out_data, k);
            checkOutput("stream_level", {30'b0, level}, 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("stream_drain_level", {30'b0, level}, 32'd0);

        // 3. stall: 5,6 fill the stage, 7 is held off, then drain in order
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'd6, 1'b0, 1'b0);
        stepCycle();
        checkOutput("stall_level", {30'b0, level}, 32'd2);
        checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("stall_data", out_data, 32'd5);
        applyStimulus(1'b1, 32'd7, 1'b0, 1'b0);
        stepCycle();
        checkOutput("held_level", {30'b0, level}, 32'd2);
        checkOutput("held_data", out_data, 32'd5);
        applyStimulus(1'b1, 32'd7, 1'b1, 1'b0);
        stepCycle();
        checkOutput("drain_data6", out_data, 32'd6);
        checkOutput("drain_level6", {30'b0, level}, 32'd1);
        checkOutput("drain_ready6", {31'b0, in_ready}, 32'd1);
        stepCycle();
        checkOutput("drain_data7", out_data, 32'd7);
        checkOutput("drain_level7", {30'b0, level}, 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("drain_empty", {30'b0, level}, 32'd0);

        // 4. flush while full with an offered beat that must be dropped
        applyStimulus(1'b1, 32'd5, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'd6, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b1);
        stepCycle();
        checkOutput("flush_level", {30'b0, level}, 32'd0);
        checkOutput("flush_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("flush_data_kept", out_data, 32'd5);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("flush_after_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_no9", out_data, 32'd5);

        // 5. random valid/ready/flush against a reference queue
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic v, r, f, ifire, ofire;
            logic [DW-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 63) == 0);
            d = $urandom;
            applyStimulus(v, d, r, f);
            ifire = v && (model_q.size() < 2);
            ofire = r && (model_q.size() > 0);
            stepCycle();
            if (f) begin
                model_q.delete();
            end else begin
                if (ofire) void'(model_q.pop_front());
                if (ifire) model_q.push_back(d);
            end
            checkOutput("rand_valid", {31'b0, out_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
            checkOutput("rand_level", {30'b0, level}, model_q.size());
            checkOutput("rand_in_ready", {31'b0, in_ready}, (model_q.size() < 2) ? 32'd1 : 32'd0);
            if (model_q.size() > 0) checkOutput("rand_data", out_data, model_q[0]);
            if (tests_failed > 20) break;
        end

        // 6. asynchronous reset while full
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
        stepCycle();
        checkOutput("pre_reset_level", {30'b0, level}, 32'd2);
        #2;
        data_ini = 32'hA5A5_5A5A;
        rst_n    = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("async_rst_level", {30'b0, level}, 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("post_rst_data", out_data, 32'hA5A5_5A5A);
        checkOutput("post_rst_valid", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
